regfile_scoreboard: RTL and testbench

Eight-entry, 16-bit register file with a per-register pending-write scoreboard. It sits directly downstream of instruction decode. It consumes the decoded read/write register specifiers, supplies operand data, and raises a stall when a source register still has an uncommitted write in flight. Writeback retires pending writes and updates the array.

---
 rtl/regfile_scoreboard_pkg.sv | 8 +
 rtl/pending_ctr.sv | 26 ++
 rtl/regfile_scoreboard.sv | 74 +++++++
 tb/tb_regfile_scoreboard.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing constants for the register file and its pending-write scoreboard.
package regfile_scoreboard_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 8;
  localparam int REG_W      = 3;
  localparam int CNT_W      = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;
endpackage

// File: rtl/pending_ctr.sv
// Saturating up/down counter of in-flight writes for one register.
module pending_ctr
  import regfile_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  // A retire against an empty counter is flagged but never wraps.
  assign underflow = dec && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && count != CNT_MAX) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 8x16 register file with per-register pending-write scoreboard and issue stall.
// Optional writeback-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_W-1:0]      read1RegSel,
  input  logic [REG_W-1:0]      read2RegSel,
  input  logic                  read1En,
  input  logic                  read2En,
  input  logic                  issueValid,
  input  logic                  issueWriteEn,
  input  logic [REG_W-1:0]      issueWriteReg,
  input  logic                  writeEn,
  input  logic [REG_W-1:0]      writeRegSel,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] read1Data,
  output logic [DATA_WIDTH-1:0] read2Data,
  output logic                  stall,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]      cnt  [NUM_REGS];
  logic [NUM_REGS-1:0]   underflow;
  logic                  haz1, haz2, issue_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (writeEn) begin
      regs[writeRegSel] <= writeData;
    end
  end

  always_comb begin
    read1Data = regs[read1RegSel];
    read2Data = regs[read2RegSel];
    haz1      = read1En && (cnt[read1RegSel] != '0);
    haz2      = read2En && (cnt[read2RegSel] != '0);
`ifdef REGFILE_BYPASS_EN
    // The last outstanding write retiring this cycle resolves the hazard.
    if (writeEn && writeRegSel == read1RegSel) begin
      read1Data = writeData;
      if (cnt[read1RegSel] == 2'd1) haz1 = 1'b0;
    end
    if (writeEn && writeRegSel == read2RegSel) begin
      read2Data = writeData;
      if (cnt[read2RegSel] == 2'd1) haz2 = 1'b0;
    end
`endif
  end

  assign stall = issueValid && (haz1 || haz2 || (issueWriteEn && cnt[issueWriteReg] == CNT_MAX));
  assign issue_accept = issueValid && !stall && issueWriteEn;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ctr
    pending_ctr u_ctr (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_accept && issueWriteReg == REG_W'(i)),
      .dec       (writeEn && writeRegSel == REG_W'(i)),
      .count     (cnt[i]),
      .underflow (underflow[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= |underflow;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector table plus randomized run against a behavioural scoreboard model.
module tb_regfile_scoreboard;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 0;
  logic        rst;
  logic [2:0]  read1RegSel, read2RegSel, issueWriteReg, writeRegSel;
  logic        read1En, read2En, issueValid, issueWriteEn, writeEn;
  logic [15:0] writeData, read1Data, read2Data;
  logic        stall, err;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1En(read1En), .read2En(read2En),
    .issueValid(issueValid), .issueWriteEn(issueWriteEn), .issueWriteReg(issueWriteReg),
    .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
    .read1Data(read1Data), .read2Data(read2Data),
    .stall(stall), .err(err)
  );

  typedef struct {
    bit rst, chk;
    logic [2:0] r1s; bit r1e;
    logic [2:0] r2s; bit r2e;
    bit iv, iwe; logic [2:0] iwr;
    bit we; logic [2:0] ws; logic [15:0] wd;
    logic [15:0] e1, e2; bit es, ee;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nmis = 0;

  int m_regs [8];
  int m_cnt  [8];
  bit m_err;

  function automatic vec_t mk(bit rs, bit ck, int r1s, bit r1e, int r2s, bit r2e,
                              bit iv, bit iwe, int iwr, bit we, int ws, int wd,
                              int e1, int e2, bit es, bit ee);
    vec_t v;
    v.rst = rs; v.chk = ck;
    v.r1s = r1s[2:0]; v.r1e = r1e; v.r2s = r2s[2:0]; v.r2e = r2e;
    v.iv = iv; v.iwe = iwe; v.iwr = iwr[2:0];
    v.we = we; v.ws = ws[2:0]; v.wd = wd[15:0];
    v.e1 = e1[15:0]; v.e2 = e2[15:0]; v.es = es; v.ee = ee;
    return v;
  endfunction

  task automatic check(string nm, int idx, logic [15:0] act, logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst;
    read1RegSel = v.r1s; read1En = v.r1e;
    read2RegSel = v.r2s; read2En = v.r2e;
    issueValid = v.iv; issueWriteEn = v.iwe; issueWriteReg = v.iwr;
    writeEn = v.we; writeRegSel = v.ws; writeData = v.wd;
  endtask

  initial begin
    vec_t v;
    int   e1, e2, es, h1, h2, ws, inc_r, dec_r, cyc;
    bit   skip;

    // rst chk | r1s r1e r2s r2e | iv iwe iwr | we ws wd | e1 e2 stall err
    tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(0,1, 0,1,7,1, 0,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(0,1, 3,1,5,1, 0,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(0,1, 0,0,3,1, 0,0,0, 1,3,'h1234,  0,BYPASS?'h1234:0,0,0));
    tbl.push_back(mk(0,1, 0,0,3,1, 0,0,0, 0,0,0,       0,'h1234,0,1));
    tbl.push_back(mk(0,1, 0,0,3,0, 1,1,5, 0,0,0,       0,'h1234,0,0));
    tbl.push_back(mk(0,1, 5,1,3,0, 1,0,0, 0,0,0,       0,'h1234,1,0));
    tbl.push_back(mk(0,1, 5,0,3,0, 1,0,0, 0,0,0,       0,'h1234,0,0));
    tbl.push_back(mk(0,1, 5,1,3,0, 1,0,0, 1,5,'h0055,  BYPASS?'h55:0,'h1234,!BYPASS,0));
    tbl.push_back(mk(0,1, 5,1,3,0, 1,0,0, 0,0,0,       'h55,'h1234,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1, 5,0,3,0, 1,1,2, 0,0,0,     'h55,'h1234,0,0));
    tbl.push_back(mk(0,1, 5,0,3,0, 1,1,2, 0,0,0,       'h55,'h1234,1,0));
    tbl.push_back(mk(0,1, 5,0,2,1, 1,0,0, 0,0,0,       'h55,0,1,0));
    tbl.push_back(mk(0,1, 2,0,3,0, 0,0,0, 1,2,'h0a0a,  BYPASS?'h0a0a:0,'h1234,0,0));
    tbl.push_back(mk(0,1, 2,0,3,0, 0,0,0, 1,2,'h0b0b,  BYPASS?'h0b0b:'h0a0a,'h1234,0,0));
    tbl.push_back(mk(0,1, 2,0,3,0, 0,0,0, 1,2,'h0c0c,  BYPASS?'h0c0c:'h0b0b,'h1234,0,0));
    tbl.push_back(mk(0,1, 2,1,3,0, 1,0,0, 0,0,0,       'h0c0c,'h1234,0,0));
    tbl.push_back(mk(0,1, 4,0,3,0, 1,1,4, 0,0,0,       0,'h1234,0,0));
    tbl.push_back(mk(0,1, 4,0,3,0, 1,1,4, 1,4,'h0444,  BYPASS?'h444:0,'h1234,0,0));
    tbl.push_back(mk(0,1, 4,1,3,0, 1,0,0, 0,0,0,       'h444,'h1234,1,0));
    tbl.push_back(mk(0,1, 4,0,3,0, 0,0,0, 1,4,'h0440,  BYPASS?'h440:'h444,'h1234,0,0));
    tbl.push_back(mk(0,1, 4,1,3,0, 1,0,0, 0,0,0,       'h440,'h1234,0,0));
    tbl.push_back(mk(0,1, 4,0,6,1, 0,0,0, 1,6,'h6666,  'h440,BYPASS?'h6666:0,0,0));
    tbl.push_back(mk(0,1, 4,0,6,1, 0,0,0, 0,0,0,       'h440,'h6666,0,1));
    tbl.push_back(mk(0,1, 1,0,6,0, 1,1,1, 0,0,0,       0,'h6666,0,0));
    tbl.push_back(mk(0,1, 1,0,6,0, 1,1,1, 1,1,'h1111,  BYPASS?'h1111:0,'h6666,0,0));
    tbl.push_back(mk(0,1, 1,0,6,0, 1,1,1, 0,0,0,       'h1111,'h6666,0,0));
    tbl.push_back(mk(1,0, 1,0,3,0, 1,1,1, 1,3,'hffff,  0,0,0,0));
    tbl.push_back(mk(0,1, 1,1,3,1, 0,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(0,1, 1,1,3,1, 1,0,0, 0,0,0,       0,0,0,0));
    tbl.push_back(mk(0,1, 6,1,1,1, 1,1,3, 0,0,0,       0,0,0,0));

    drive(tbl[0]);
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      if (tbl[i].chk) begin
        check("read1Data", i, read1Data, tbl[i].e1);
        check("read2Data", i, read2Data, tbl[i].e2);
        check("stall", i, {15'd0, stall}, {15'd0, tbl[i].es});
        check("err", i, {15'd0, err}, {15'd0, tbl[i].ee});
      end
      @(posedge clk); #1;
    end

    // Randomized run; first cycle is a reset that aligns model and DUT.
    for (int k = 0; k < 8; k++) begin m_regs[k] = 0; m_cnt[k] = 0; end
    m_err = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      skip = (cyc == 0);
      v.rst = skip || ($urandom_range(0, 199) == 0);
      v.r1s = 3'($urandom_range(0, 7)); v.r1e = $urandom_range(0, 1);
      v.r2s = 3'($urandom_range(0, 7)); v.r2e = $urandom_range(0, 1);
      v.iv  = ($urandom_range(0, 9) < 7); v.iwe = ($urandom_range(0, 9) < 7);
      v.iwr = 3'($urandom_range(0, 7));
      v.we  = ($urandom_range(0, 9) < 4);
      ws = $urandom_range(0, 7);
      if ($urandom_range(0, 7) != 0)
        for (int k = 0; k < 8; k++)
          if (m_cnt[(ws + k) % 8] != 0) begin ws = (ws + k) % 8; break; end
      v.ws = 3'(ws);
      v.wd = 16'($urandom);
      drive(v);
      @(negedge clk);

      e1 = (BYPASS && v.we && v.ws == v.r1s) ? int'(v.wd) : m_regs[v.r1s];
      e2 = (BYPASS && v.we && v.ws == v.r2s) ? int'(v.wd) : m_regs[v.r2s];
      h1 = v.r1e && m_cnt[v.r1s] > 0 && !(BYPASS && v.we && v.ws == v.r1s && m_cnt[v.r1s] == 1);
      h2 = v.r2e && m_cnt[v.r2s] > 0 && !(BYPASS && v.we && v.ws == v.r2s && m_cnt[v.r2s] == 1);
      es = v.iv && (h1 || h2 || (v.iwe && m_cnt[v.iwr] == 3));
      if (!skip) begin
        check("rand read1Data", cyc, read1Data, 16'(e1));
        check("rand read2Data", cyc, read2Data, 16'(e2));
        check("rand stall", cyc, {15'd0, stall}, 16'(es));
        check("rand err", cyc, {15'd0, err}, {15'd0, m_err});
      end

      if (v.rst) begin
        for (int k = 0; k < 8; k++) begin m_regs[k] = 0; m_cnt[k] = 0; end
        m_err = 0;
      end else begin
        inc_r = (v.iv && v.iwe && es == 0) ? int'(v.iwr) : -1;
        dec_r = v.we ? int'(v.ws) : -1;
        m_err = v.we && m_cnt[v.ws] == 0;
        if (v.we) m_regs[v.ws] = int'(v.wd);
        if (inc_r != dec_r) begin
          if (inc_r >= 0) m_cnt[inc_r] = m_cnt[inc_r] + 1;
          if (dec_r >= 0 && m_cnt[dec_r] > 0) m_cnt[dec_r] = m_cnt[dec_r] - 1;
        end
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
